// File: rtl/key_debouncer_if.sv
// Key debouncer bus: raw key pins in, debounced press pulses and levels out.
// Signal names match the debouncer's external pin names.
interface key_debouncer_if #(
    parameter int unsigned NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] i_keys;
    logic [NUM_KEYS-1:0] o_pulse;
    logic [NUM_KEYS-1:0] o_level;

    modport master (output i_keys, input o_pulse, input o_level);
    modport slave (input i_keys, output o_pulse, output o_level);
endinterface

// File: rtl/key_debouncer.sv
// Per-key 2-flop synchroniser, debounce FSM, one-cycle press pulse and optional auto-repeat.
// All outputs are registered; reset is synchronous and active low.
module key_debouncer #(
    parameter int unsigned         NUM_KEYS        = 4,
    parameter bit                  ACTIVE_LOW      = 1'b1,
    parameter int unsigned         DEBOUNCE_CYCLES = 500000,
    parameter logic [NUM_KEYS-1:0] REPEAT_MASK     = NUM_KEYS'(4'b1100),
    parameter int unsigned         REPEAT_DELAY    = 25000000,
    parameter int unsigned         REPEAT_PERIOD   = 5000000
) (
    input logic            i_clk,
    input logic            i_rst_n,
    key_debouncer_if.slave bus
);
    localparam int unsigned CntW   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned RcntW  = (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;
    localparam int unsigned PcntW  = $clog2(REPEAT_PERIOD + 1);

    localparam logic [CntW-1:0]  CntLast   = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RcntW-1:0] RcntMax   = RcntW'(REPEAT_DELAY);
    localparam logic [RcntW-1:0] RcntLast  = RcntW'(REPEAT_DELAY - 1);
    localparam logic [PcntW-1:0] PcntLast  = PcntW'(REPEAT_PERIOD - 1);
    localparam logic [NUM_KEYS-1:0] Released = {NUM_KEYS{ACTIVE_LOW}};

    typedef enum logic [1:0] {StIdle, StDbPress, StHeld, StDbRelease} state_e;

    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] pressed;
    logic [NUM_KEYS-1:0] pulse_vec, level_vec;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1_q <= Released;
            sync2_q <= Released;
        end else begin
            sync1_q <= bus.i_keys;
            sync2_q <= sync1_q;
        end
    end

    // Normalise so that 1 always means pressed.
    assign pressed = ACTIVE_LOW ? ~sync2_q : sync2_q;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        localparam bit RepeatEn = REPEAT_MASK[k] && (REPEAT_DELAY > 0);

        state_e           state_q;
        logic [CntW-1:0]  cnt_q;
        logic [RcntW-1:0] rcnt_q;
        logic [PcntW-1:0] pcnt_q;
        logic             pulse_q;
        logic             level_q;

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                rcnt_q  <= '0;
                pcnt_q  <= '0;
                pulse_q <= 1'b0;
                level_q <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                unique case (state_q)
                    StIdle: begin
                        if (pressed[k]) begin
                            state_q <= StDbPress;
                            cnt_q   <= CntW'(1);
                            rcnt_q  <= '0;
                            pcnt_q  <= '0;
                        end
                    end
                    StDbPress: begin
                        if (!pressed[k]) begin
                            state_q <= StIdle;
                            cnt_q   <= '0;
                        end else if (cnt_q == CntLast) begin
                            state_q <= StHeld;
                            cnt_q   <= '0;
                            pulse_q <= 1'b1;
                            level_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                    StHeld: begin
                        if (!pressed[k]) begin
                            state_q <= StDbRelease;
                            cnt_q   <= CntW'(1);
                        end else if (RepeatEn) begin
                            // rcnt stops at the delay; pcnt then paces the later repeats.
                            if (rcnt_q != RcntMax) begin
                                rcnt_q <= rcnt_q + RcntW'(1);
                                if (rcnt_q == RcntLast) begin
                                    pulse_q <= 1'b1;
                                    pcnt_q  <= '0;
                                end
                            end else if (pcnt_q == PcntLast) begin
                                pcnt_q  <= '0;
                                pulse_q <= 1'b1;
                            end else begin
                                pcnt_q <= pcnt_q + PcntW'(1);
                            end
                        end
                    end
                    StDbRelease: begin
                        if (pressed[k]) begin
                            state_q <= StHeld;
                        end else if (cnt_q == CntLast) begin
                            state_q <= StIdle;
                            cnt_q   <= '0;
                            level_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end

        assign pulse_vec[k] = pulse_q;
        assign level_vec[k] = level_q;
    end

    assign bus.o_pulse = pulse_vec;
    assign bus.o_level = level_vec;
endmodule
